// File: rtl/dram_gate_pkg.sv
// Shared types for the DRAM AXI gate: FSM states, response codes and AXI4 bundles.
package dram_gate_pkg;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned BusAddrW  = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned UserWidth = 1;
    localparam int unsigned LenWidth  = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ERR_DATA,
        W_ERR_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_ERR_DATA
    } r_state_e;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [BusAddrW-1:0]  addr;
        logic [LenWidth-1:0]  len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [UserWidth-1:0] user;
    } ax_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
        logic [UserWidth-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } gate_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } gate_resp_t;

endpackage

// File: rtl/sync.sv
// Multi-stage flop synchronizer for a single asynchronous level signal.
module sync #(
    parameter int unsigned STAGES     = 2,
    parameter bit          ResetValue = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic serial_i,
    output logic serial_o
);

    logic [STAGES-1:0] reg_q;

    // Shift the input through the synchronizer chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_q <= {STAGES{ResetValue}};
        end else begin
            reg_q <= {reg_q[STAGES-2:0], serial_i};
        end
    end

    assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/dram_axi_gate.sv
// Gates SoC AXI traffic into the DRAM path: holds off until calibration, caps
// outstanding transactions and answers out-of-window accesses with DECERR.
module dram_axi_gate
    import dram_gate_pkg::*;
#(
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned DramAddrWidth = 29,
    parameter int unsigned MaxTxns       = 8,
    parameter type         axi_req_t     = dram_gate_pkg::gate_req_t,
    parameter type         axi_resp_t    = dram_gate_pkg::gate_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      calib_done_i,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o,
    output axi_req_t  mst_req_o,
    input  axi_resp_t mst_resp_i,
    output logic      calib_done_o,
    output logic      err_o
);

    localparam int unsigned CntWidth = $clog2(MaxTxns + 1);

    logic                calib_q;
    w_state_e            w_state_q, w_state_d;
    r_state_e            r_state_q, r_state_d;
    logic [CntWidth-1:0] wr_cnt_q, rd_cnt_q, wfwd_cnt_q;
    logic [IdWidth-1:0]  b_id_q, r_id_q;
    logic [LenWidth-1:0] r_len_q, beat_q;
    logic                err_q;

    logic aw_in_range, ar_in_range;
    logic aw_fwd_en, ar_fwd_en, aw_err_en, ar_err_en;
    logic w_pass, wr_busy, rd_busy;
    logic mst_aw_hs, mst_ar_hs, mst_b_hs, mst_r_last_hs, mst_w_last_hs;
    logic aw_err_hs, ar_err_hs, r_err_hs;

    // Calibration status crosses into clk_i through a two-stage synchronizer.
    sync #(
        .STAGES     (2),
        .ResetValue (1'b0)
    ) i_calib_sync (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .serial_i (calib_done_i),
        .serial_o (calib_q)
    );

    assign aw_in_range = ~|slv_req_i.aw.addr[AddrWidth-1:DramAddrWidth];
    assign ar_in_range = ~|slv_req_i.ar.addr[AddrWidth-1:DramAddrWidth];

    // Error bursts are only taken once the direction has fully drained.
    assign aw_fwd_en = calib_q && (w_state_q == W_IDLE) && (wr_cnt_q < CntWidth'(MaxTxns)) && aw_in_range;
    assign ar_fwd_en = calib_q && (r_state_q == R_IDLE) && (rd_cnt_q < CntWidth'(MaxTxns)) && ar_in_range;
    assign aw_err_en = calib_q && (w_state_q == W_IDLE) && (wr_cnt_q == '0) && !aw_in_range;
    assign ar_err_en = calib_q && (r_state_q == R_IDLE) && (rd_cnt_q == '0) && !ar_in_range;

    assign w_pass  = (wfwd_cnt_q != '0) && (w_state_q == W_IDLE);
    // Responses only flow while something is outstanding, so nothing leaks out of reset.
    assign wr_busy = (wr_cnt_q != '0);
    assign rd_busy = (rd_cnt_q != '0);

    assign mst_aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    assign mst_ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    assign mst_b_hs      = mst_resp_i.b_valid & mst_req_o.b_ready;
    assign mst_r_last_hs = mst_resp_i.r_valid & mst_req_o.r_ready & mst_resp_i.r.last;
    assign mst_w_last_hs = mst_req_o.w_valid & mst_resp_i.w_ready & slv_req_i.w.last;
    assign aw_err_hs     = slv_req_i.aw_valid & aw_err_en;
    assign ar_err_hs     = slv_req_i.ar_valid & ar_err_en;
    assign r_err_hs      = (r_state_q == R_ERR_DATA) & slv_req_i.r_ready;

    // FSM state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    // Next-state logic and channel muxing between pass-through and DECERR responder.
    always_comb begin
        w_state_d  = w_state_q;
        r_state_d  = r_state_q;
        mst_req_o  = slv_req_i;
        slv_resp_o = mst_resp_i;

        mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_fwd_en;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_fwd_en;
        mst_req_o.w_valid   = slv_req_i.w_valid & w_pass;
        mst_req_o.b_ready   = slv_req_i.b_ready & wr_busy & (w_state_q == W_IDLE);
        mst_req_o.r_ready   = slv_req_i.r_ready & rd_busy & (r_state_q == R_IDLE);
        slv_resp_o.aw_ready = aw_fwd_en ? mst_resp_i.aw_ready : aw_err_en;
        slv_resp_o.ar_ready = ar_fwd_en ? mst_resp_i.ar_ready : ar_err_en;
        slv_resp_o.w_ready  = (w_state_q == W_ERR_DATA) | (w_pass & mst_resp_i.w_ready);
        slv_resp_o.b_valid  = mst_resp_i.b_valid & wr_busy & (w_state_q == W_IDLE);
        slv_resp_o.r_valid  = mst_resp_i.r_valid & rd_busy & (r_state_q == R_IDLE);

        case (w_state_q)
            W_IDLE: begin
                if (aw_err_hs) w_state_d = W_ERR_DATA;
            end
            W_ERR_DATA: begin
                if (slv_req_i.w_valid && slv_req_i.w.last) w_state_d = W_ERR_RESP;
            end
            W_ERR_RESP: begin
                slv_resp_o.b_valid = 1'b1;
                slv_resp_o.b.id    = b_id_q;
                slv_resp_o.b.resp  = RESP_DECERR;
                slv_resp_o.b.user  = '0;
                if (slv_req_i.b_ready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase

        case (r_state_q)
            R_IDLE: begin
                if (ar_err_hs) r_state_d = R_ERR_DATA;
            end
            R_ERR_DATA: begin
                slv_resp_o.r_valid = 1'b1;
                slv_resp_o.r.id    = r_id_q;
                slv_resp_o.r.data  = '0;
                slv_resp_o.r.resp  = RESP_DECERR;
                slv_resp_o.r.last  = (beat_q == r_len_q);
                slv_resp_o.r.user  = '0;
                if (slv_req_i.r_ready && (beat_q == r_len_q)) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Outstanding-transaction and pending-W-burst counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wfwd_cnt_q <= '0;
        end else begin
            wr_cnt_q   <= wr_cnt_q + CntWidth'(mst_aw_hs) - CntWidth'(mst_b_hs);
            rd_cnt_q   <= rd_cnt_q + CntWidth'(mst_ar_hs) - CntWidth'(mst_r_last_hs);
            wfwd_cnt_q <= wfwd_cnt_q + CntWidth'(mst_aw_hs) - CntWidth'(mst_w_last_hs);
        end
    end

    // Capture error-burst attributes and walk the DECERR read beats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_id_q  <= '0;
            r_id_q  <= '0;
            r_len_q <= '0;
            beat_q  <= '0;
        end else begin
            if (aw_err_hs) b_id_q <= slv_req_i.aw.id;
            if (ar_err_hs) begin
                r_id_q  <= slv_req_i.ar.id;
                r_len_q <= slv_req_i.ar.len;
                beat_q  <= '0;
            end else if (r_err_hs) begin
                beat_q  <= beat_q + LenWidth'(1);
            end
        end
    end

    // One pulse per accepted out-of-range request; both directions merge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= aw_err_hs | ar_err_hs;
        end
    end

    assign calib_done_o = calib_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_dram_axi_gate.sv
// Directed bench for dram_axi_gate: combinational gating table plus burst sequences.
module tb_dram_axi_gate;
    import dram_gate_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       calib_in;
    gate_req_t  slv_req, mst_req;
    gate_resp_t slv_resp, mst_resp;
    logic       calib_out, err;

    int n_tests = 0;
    int n_fail  = 0;
    int err_hi  = 0;
    int hi;

    always #5 clk = ~clk;

    dram_axi_gate #(
        .AddrWidth     (64),
        .DramAddrWidth (29),
        .MaxTxns       (8),
        .axi_req_t     (gate_req_t),
        .axi_resp_t    (gate_resp_t)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .calib_done_i (calib_in),
        .slv_req_i    (slv_req),
        .slv_resp_o   (slv_resp),
        .mst_req_o    (mst_req),
        .mst_resp_i   (mst_resp),
        .calib_done_o (calib_out),
        .err_o        (err)
    );

    typedef struct {
        logic        aw_valid;
        logic [63:0] aw_addr;
        logic        mst_aw_ready;
        logic        ar_valid;
        logic [63:0] ar_addr;
        logic        mst_ar_ready;
        logic        exp_aw_ready;
        logic        exp_mst_aw_valid;
        logic        exp_ar_ready;
        logic        exp_mst_ar_valid;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Let combinational outputs settle after a negedge drive, tallying err_o pulses.
    task automatic settle();
        #1;
        if (err === 1'b1) err_hi++;
    endtask

    function automatic logic [11:0] vld_rdy();
        return {slv_resp.aw_ready, slv_resp.ar_ready, slv_resp.w_ready, slv_resp.b_valid,
                slv_resp.r_valid, mst_req.aw_valid, mst_req.ar_valid, mst_req.w_valid,
                mst_req.b_ready, mst_req.r_ready, calib_out, err};
    endfunction

    task automatic do_reset(input logic calib);
        rst_n    = 1'b0;
        slv_req  = '0;
        mst_resp = '0;
        calib_in = calib;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        err_hi = 0;
    endtask

    initial begin
        // Reset state with every input valid/ready asserted.
        rst_n    = 1'b0;
        calib_in = 1'b1;
        slv_req  = '0;
        mst_resp = '0;
        slv_req.aw_valid = 1'b1; slv_req.ar_valid = 1'b1; slv_req.w_valid = 1'b1;
        slv_req.b_ready  = 1'b1; slv_req.r_ready  = 1'b1;
        mst_resp.aw_ready = 1'b1; mst_resp.ar_ready = 1'b1; mst_resp.w_ready = 1'b1;
        mst_resp.b_valid  = 1'b1; mst_resp.r_valid  = 1'b1;
        #2;
        check("reset_outputs", 64'(vld_rdy()), 64'd0);
        @(negedge clk); @(negedge clk); #1;
        check("reset_outputs_held", 64'(vld_rdy()), 64'd0);

        // Uncalibrated: AR held off, then released two cycles after calibration.
        do_reset(1'b0);
        @(negedge clk);
        slv_req.ar_valid = 1'b1; slv_req.ar.addr = 64'h100; mst_resp.ar_ready = 1'b1;
        hi = 0;
        repeat (4) begin
            settle();
            if (slv_resp.ar_ready || mst_req.ar_valid) hi++;
            @(negedge clk);
        end
        check("ar_blocked_uncal", 64'(hi), 64'd0);
        calib_in = 1'b1;
        settle();
        check("ar_rdy_cycle1", 64'(slv_resp.ar_ready), 64'd0);
        @(negedge clk); settle();
        check("ar_rdy_cycle2", 64'(slv_resp.ar_ready), 64'd0);
        @(negedge clk); settle();
        check("ar_rdy_cycle3", 64'({slv_resp.ar_ready, mst_req.ar_valid, calib_out}), 64'b111);
        slv_req.ar_valid = 1'b0;

        // Combinational AW/AR gating table (no handshakes complete).
        vecs[0] = '{1'b1, 64'h1000,              1'b0, 1'b0, 64'h100,              1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 64'h1FFF_FFFF,         1'b1, 1'b1, 64'h1FFF_FFC0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 64'h2000_0000,         1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 64'h2000_0000,         1'b1, 1'b0, 64'h1000_0000,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 64'h0,                 1'b0, 1'b1, 64'h1FFF_FFFF,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 64'h0,                 1'b0, 1'b0, 64'h0,                1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            slv_req.aw_valid   = vecs[i].aw_valid;
            slv_req.aw.addr    = vecs[i].aw_addr;
            mst_resp.aw_ready  = vecs[i].mst_aw_ready;
            slv_req.ar_valid   = vecs[i].ar_valid;
            slv_req.ar.addr    = vecs[i].ar_addr;
            mst_resp.ar_ready  = vecs[i].mst_ar_ready;
            settle();
            check($sformatf("tbl%0d_aw_ready", i), 64'(slv_resp.aw_ready), 64'(vecs[i].exp_aw_ready));
            check($sformatf("tbl%0d_mst_aw_valid", i), 64'(mst_req.aw_valid), 64'(vecs[i].exp_mst_aw_valid));
            check($sformatf("tbl%0d_ar_ready", i), 64'(slv_resp.ar_ready), 64'(vecs[i].exp_ar_ready));
            check($sformatf("tbl%0d_mst_ar_valid", i), 64'(mst_req.ar_valid), 64'(vecs[i].exp_mst_ar_valid));
        end

        // Eight outstanding writes fill the window; one B reopens it.
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            slv_req.aw_valid = 1'b1; slv_req.aw.addr = 64'(i) * 64'h1000;
            slv_req.aw.id = 4'(i); mst_resp.aw_ready = 1'b1;
            settle();
            check($sformatf("aw_fwd%0d", i),
                  64'({slv_resp.aw_ready, mst_req.aw_valid, mst_req.aw.addr[15:0]}),
                  64'({2'b11, 16'(i * 'h1000)}));
        end
        @(negedge clk);
        slv_req.aw.addr = 64'h9000;
        settle();
        check("aw_ninth_stall", 64'({slv_resp.aw_ready, mst_req.aw_valid}), 64'b00);
        mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd3; mst_resp.b.resp = RESP_OKAY;
        slv_req.b_ready = 1'b1;
        #1;
        check("b_passthru", 64'({slv_resp.b_valid, slv_resp.b.id, slv_resp.b.resp, mst_req.b_ready}),
              64'({1'b1, 4'd3, 2'b00, 1'b1}));
        @(negedge clk);
        mst_resp.b_valid = 1'b0;
        settle();
        check("aw_ninth_accept", 64'({slv_resp.aw_ready, mst_req.aw_valid}), 64'b11);

        // Out-of-range write: four W beats sunk, DECERR B, single err pulse.
        do_reset(1'b1);
        hi = 0;
        @(negedge clk);
        slv_req.aw_valid = 1'b1; slv_req.aw.addr = 64'h2000_0000; slv_req.aw.len = 8'd3;
        slv_req.aw.id = 4'd6; mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1;
        settle();
        check("aw_err_accept", 64'({slv_resp.aw_ready, mst_req.aw_valid}), 64'b10);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            slv_req.aw_valid = 1'b0;
            slv_req.w_valid = 1'b1; slv_req.w.last = (b == 3); slv_req.w.data = 64'hA5A5 + 64'(b);
            settle();
            check($sformatf("w_sink%0d", b), 64'(slv_resp.w_ready), 64'd1);
            if (mst_req.w_valid || mst_req.aw_valid) hi++;
        end
        @(negedge clk);
        slv_req.w_valid = 1'b0; slv_req.b_ready = 1'b0;
        settle();
        check("b_err_resp", 64'({slv_resp.b_valid, slv_resp.b.id, slv_resp.b.resp, slv_resp.b.user, mst_req.b_ready}),
              64'({1'b1, 4'd6, 2'b11, 1'b0, 1'b0}));
        @(negedge clk);
        slv_req.b_ready = 1'b1;
        settle();
        check("b_err_held", 64'({slv_resp.b_valid, slv_resp.b.id}), 64'({1'b1, 4'd6}));
        @(negedge clk);
        slv_req.b_ready = 1'b0;
        settle();
        check("b_err_done", 64'(slv_resp.b_valid), 64'd0);
        check("w_err_no_leak", 64'(hi), 64'd0);
        check("w_err_pulses", 64'(err_hi), 64'd1);

        // Out-of-range read: eight zero DECERR beats, last on the eighth.
        do_reset(1'b1);
        @(negedge clk);
        slv_req.ar_valid = 1'b1; slv_req.ar.addr = 64'h4000_0000; slv_req.ar.len = 8'd7;
        slv_req.ar.id = 4'd5; mst_resp.ar_ready = 1'b1;
        settle();
        check("ar_err_accept", 64'({slv_resp.ar_ready, mst_req.ar_valid}), 64'b10);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            slv_req.ar_valid = 1'b0; slv_req.r_ready = 1'b1; mst_resp.r_valid = 1'b1;
            mst_resp.r.data = 64'hFFFF;
            settle();
            check($sformatf("r_err_beat%0d", b),
                  64'({slv_resp.r_valid, slv_resp.r.id, slv_resp.r.resp, slv_resp.r.last, mst_req.r_ready}),
                  64'({1'b1, 4'd5, 2'b11, (b == 7), 1'b0}));
            check($sformatf("r_err_data%0d", b), slv_resp.r.data, 64'd0);
        end
        @(negedge clk);
        settle();
        check("r_err_done", 64'(slv_resp.r_valid), 64'd0);
        check("r_err_pulses", 64'(err_hi), 64'd1);

        // Out-of-range write waits for two outstanding in-range writes to retire.
        do_reset(1'b1);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            slv_req.aw_valid = 1'b1; slv_req.aw.addr = 64'h100; slv_req.aw.id = 4'(i);
            mst_resp.aw_ready = 1'b1;
        end
        @(negedge clk);
        slv_req.aw.addr = 64'h2000_0000; slv_req.aw.id = 4'd9;
        settle();
        check("aw_oor_wait2", 64'({slv_resp.aw_ready, mst_req.aw_valid}), 64'b00);
        @(negedge clk);
        mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd1; slv_req.b_ready = 1'b1;
        settle();
        check("aw_oor_wait_b1", 64'(slv_resp.aw_ready), 64'd0);
        @(negedge clk);
        mst_resp.b.id = 4'd2;
        settle();
        check("aw_oor_wait_b2", 64'(slv_resp.aw_ready), 64'd0);
        @(negedge clk);
        mst_resp.b_valid = 1'b0;
        settle();
        check("aw_oor_accept", 64'({slv_resp.aw_ready, mst_req.aw_valid}), 64'b10);
        @(negedge clk);
        slv_req.aw_valid = 1'b0;
        settle();
        check("aw_oor_err_data", 64'({slv_resp.w_ready, err}), 64'b11);

        // Reset in the middle of a DECERR read burst.
        do_reset(1'b1);
        @(negedge clk);
        slv_req.ar_valid = 1'b1; slv_req.ar.addr = 64'h4000_0000; slv_req.ar.len = 8'd7;
        slv_req.ar.id = 4'd3;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            slv_req.ar_valid = 1'b0; slv_req.r_ready = 1'b1;
        end
        settle();
        check("r_beat3_before_rst", 64'({slv_resp.r_valid, slv_resp.r.last}), 64'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_burst_reset", 64'(vld_rdy()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        slv_req.r_ready = 1'b0;
        slv_req.ar.addr = 64'h4000_0000; slv_req.aw.addr = 64'h2000_0000;
        repeat (3) @(negedge clk);
        settle();
        check("post_rst_idle", 64'({slv_resp.ar_ready, slv_resp.aw_ready, slv_resp.r_valid}), 64'b110);
        @(negedge clk);
        slv_req.ar_valid = 1'b1; slv_req.ar.addr = 64'h200; slv_req.ar.id = 4'd2;
        mst_resp.ar_ready = 1'b1;
        settle();
        check("post_rst_ar_fwd", 64'({slv_resp.ar_ready, mst_req.ar_valid}), 64'b11);
        @(negedge clk);
        slv_req.ar_valid = 1'b0; slv_req.r_ready = 1'b1;
        mst_resp.r_valid = 1'b1; mst_resp.r.id = 4'd2; mst_resp.r.data = 64'hDEAD; mst_resp.r.last = 1'b1;
        settle();
        check("r_passthru", 64'({slv_resp.r_valid, mst_req.r_ready, slv_resp.r.data[15:0]}),
              64'({2'b11, 16'hDEAD}));
        @(negedge clk);
        mst_resp.r_valid = 1'b0; slv_req.ar.addr = 64'h4000_0000;
        settle();
        check("rd_cnt_drained", 64'(slv_resp.ar_ready), 64'd1);

        // Same-cycle write and read errors merge into one pulse.
        do_reset(1'b1);
        @(negedge clk);
        slv_req.aw_valid = 1'b1; slv_req.aw.addr = 64'h2000_0000;
        slv_req.ar_valid = 1'b1; slv_req.ar.addr = 64'h2000_0000;
        settle();
        check("both_err_ready", 64'({slv_resp.aw_ready, slv_resp.ar_ready}), 64'b11);
        @(negedge clk);
        slv_req.aw_valid = 1'b0; slv_req.ar_valid = 1'b0;
        settle();
        repeat (3) begin @(negedge clk); settle(); end
        check("err_same_cycle", 64'(err_hi), 64'd1);

        // Back-to-back write then read errors give two pulses.
        do_reset(1'b1);
        @(negedge clk);
        slv_req.aw_valid = 1'b1; slv_req.aw.addr = 64'h2000_0000;
        settle();
        @(negedge clk);
        slv_req.aw_valid = 1'b0;
        slv_req.ar_valid = 1'b1; slv_req.ar.addr = 64'h2000_0000;
        settle();
        @(negedge clk);
        slv_req.ar_valid = 1'b0;
        settle();
        repeat (2) begin @(negedge clk); settle(); end
        check("err_back_to_back", 64'(err_hi), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
